// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared state encodings, button indices and priority pick for the stopwatch sequencer
package stopwatch_pkg;
    typedef enum logic [1:0] {TMR_IDLE, TMR_RUN, TMR_PAUSE} tmr_state_t;
    typedef enum logic [1:0] {CD_SET, CD_RUN, CD_PAUSE, CD_DONE} cd_state_t;
    localparam int BTN_RESET = 0;
    localparam int BTN_START = 1;
    localparam int BTN_STOP  = 2;
    localparam int BTN_LAP   = 3;
    localparam int BTN_VIEW  = 4;
    function automatic logic [4:0] btn_win(input logic [4:0] b);
        btn_win = '0;
        if (b[BTN_RESET]) btn_win[BTN_RESET] = 1'b1;
        else if (b[BTN_STOP]) btn_win[BTN_STOP] = 1'b1;
        else if (b[BTN_START]) btn_win[BTN_START] = 1'b1;
        else if (b[BTN_LAP]) btn_win[BTN_LAP] = 1'b1;
        else if (b[BTN_VIEW]) btn_win[BTN_VIEW] = 1'b1;
    endfunction
endpackage

// File: rtl/stopwatch_ctrl_if.sv
// stopwatch_ctrl_if: button, switch and counter-control signals of the stopwatch sequencer
interface stopwatch_ctrl_if;
    logic s0_p, s1_p, s2_p, s3_p, s4_p;
    logic sw0_lvl, sw1_lvl, sw7_lvl, cd_zero;
    logic [1:0] run_en, clr, lap_cap;
    logic view_lap, cd_run, cd_clr, cd_min_inc, cd_hr_inc, alarm, mode_cd;
    modport master (
        output s0_p, s1_p, s2_p, s3_p, s4_p, sw0_lvl, sw1_lvl, sw7_lvl, cd_zero,
        input  run_en, clr, lap_cap, view_lap, cd_run, cd_clr, cd_min_inc, cd_hr_inc, alarm, mode_cd
    );
    modport slave (
        input  s0_p, s1_p, s2_p, s3_p, s4_p, sw0_lvl, sw1_lvl, sw7_lvl, cd_zero,
        output run_en, clr, lap_cap, view_lap, cd_run, cd_clr, cd_min_inc, cd_hr_inc, alarm, mode_cd
    );
endinterface

// File: rtl/sw_timer_fsm.sv
// sw_timer_fsm: IDLE/RUN/PAUSE sequencer for one stopwatch timer
module sw_timer_fsm
    import stopwatch_pkg::*;
(
    input  logic clk_db,
    input  logic rst,
    input  logic sel,
    input  logic start,
    input  logic stop,
    input  logic reset,
    input  logic lap,
    input  logic hold,
    output logic run_en,
    output logic clr,
    output logic lap_cap
);
    tmr_state_t state_q, state_d;
    logic run_en_q, run_en_d, clr_q, clr_d, lap_cap_q, lap_cap_d;
    // Buttons act only on the selected timer; run_en is masked while countdown mode holds the timer
    always_comb begin
        state_d = state_q;
        if (sel && reset) state_d = TMR_IDLE;
        else if (sel && stop && state_q == TMR_RUN) state_d = TMR_PAUSE;
        else if (sel && start && state_q != TMR_RUN) state_d = TMR_RUN;
        run_en_d = state_d == TMR_RUN && !hold;
        clr_d = sel && reset;
        lap_cap_d = sel && lap && state_q != TMR_IDLE;
    end
    // State and registered outputs
    always_ff @(posedge clk_db or posedge rst) begin
        if (rst) begin
            state_q   <= TMR_IDLE;
            run_en_q  <= 1'b0;
            clr_q     <= 1'b0;
            lap_cap_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            run_en_q  <= run_en_d;
            clr_q     <= clr_d;
            lap_cap_q <= lap_cap_d;
        end
    end
    assign run_en  = run_en_q;
    assign clr     = clr_q;
    assign lap_cap = lap_cap_q;
endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: button/switch sequencer for two stopwatch timers and the countdown counter
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int ALARM_TICKS = 300,
    parameter int AW          = 9
) (
    input logic clk_db,
    input logic rst,
    stopwatch_ctrl_if.slave bus
);
    logic [4:0] btn, win;
    logic sw_act, mode_chg;
    logic [1:0] sel, run_en, clr, lap_cap;
    cd_state_t cd_state_q, cd_state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic mode_cd_q, mode_cd_d, view_tog_q, view_tog_d, view_lap_q, view_lap_d;
    logic cd_run_q, cd_run_d, cd_clr_q, cd_clr_d, cd_min_q, cd_min_d, cd_hr_q, cd_hr_d, alarm_q, alarm_d;

    assign btn      = {bus.s4_p, bus.s3_p, bus.s2_p, bus.s1_p, bus.s0_p};
    assign win      = btn_win(btn);
    assign sw_act   = ~mode_cd_q;
    assign mode_chg = bus.sw7_lvl ^ mode_cd_q;
    assign sel      = {bus.sw0_lvl, ~bus.sw0_lvl};

    for (genvar i = 0; i < 2; i++) begin : g_tmr
        sw_timer_fsm u_tmr (
            .clk_db,
            .rst,
            .sel    (sel[i]),
            .start  (sw_act & win[BTN_START]),
            .stop   (sw_act & win[BTN_STOP]),
            .reset  (sw_act & win[BTN_RESET]),
            .lap    (sw_act & win[BTN_LAP]),
            .hold   (bus.sw7_lvl),
            .run_en (run_en[i]),
            .clr    (clr[i]),
            .lap_cap(lap_cap[i])
        );
    end

    // Countdown sequencing, alarm hold-off, view toggle; pulses decode under the already-registered mode
    always_comb begin
        cd_state_d = cd_state_q;
        cnt_d      = cnt_q;
        cd_clr_d   = 1'b0;
        cd_min_d   = 1'b0;
        cd_hr_d    = 1'b0;
        mode_cd_d  = bus.sw7_lvl;
        view_tog_d = view_tog_q ^ (sw_act & win[BTN_VIEW]);
        if (mode_cd_q) begin
            if (win[BTN_RESET]) begin
                cd_state_d = CD_SET;
                cd_clr_d   = 1'b1;
            end else begin
                case (cd_state_q)
                    CD_SET: begin
                        cd_min_d = win[BTN_LAP];
                        cd_hr_d  = win[BTN_VIEW];
                        if (win[BTN_START] && !bus.cd_zero) cd_state_d = CD_RUN;
                    end
                    CD_RUN: begin
                        if (bus.cd_zero) begin
                            cd_state_d = CD_DONE;
                            cnt_d      = AW'(ALARM_TICKS);
                        end else if (win[BTN_STOP]) cd_state_d = CD_PAUSE;
                    end
                    CD_PAUSE: if (win[BTN_START]) cd_state_d = CD_RUN;
                    CD_DONE: begin
                        cnt_d = cnt_q - 1'b1;
                        if (|btn || cnt_d == '0) cd_state_d = CD_SET;
                    end
                endcase
            end
        end
        if (mode_chg) cd_state_d = CD_SET;
        cd_run_d   = cd_state_d == CD_RUN;
        alarm_d    = cd_state_d == CD_DONE;
        view_lap_d = view_tog_d | bus.sw1_lvl;
    end

    // State and registered outputs; reset clears everything without issuing strobes
    always_ff @(posedge clk_db or posedge rst) begin
        if (rst) begin
            cd_state_q <= CD_SET;
            cnt_q      <= '0;
            mode_cd_q  <= 1'b0;
            view_tog_q <= 1'b0;
            view_lap_q <= 1'b0;
            cd_run_q   <= 1'b0;
            cd_clr_q   <= 1'b0;
            cd_min_q   <= 1'b0;
            cd_hr_q    <= 1'b0;
            alarm_q    <= 1'b0;
        end else begin
            cd_state_q <= cd_state_d;
            cnt_q      <= cnt_d;
            mode_cd_q  <= mode_cd_d;
            view_tog_q <= view_tog_d;
            view_lap_q <= view_lap_d;
            cd_run_q   <= cd_run_d;
            cd_clr_q   <= cd_clr_d;
            cd_min_q   <= cd_min_d;
            cd_hr_q    <= cd_hr_d;
            alarm_q    <= alarm_d;
        end
    end

    assign bus.run_en     = run_en;
    assign bus.clr        = clr;
    assign bus.lap_cap    = lap_cap;
    assign bus.view_lap   = view_lap_q;
    assign bus.cd_run     = cd_run_q;
    assign bus.cd_clr     = cd_clr_q;
    assign bus.cd_min_inc = cd_min_q;
    assign bus.cd_hr_inc  = cd_hr_q;
    assign bus.alarm      = alarm_q;
    assign bus.mode_cd    = mode_cd_q;
endmodule
